// File: rtl/acc_seq_ctrl.sv
// Purpose : fetch/decode/execute sequencer for the accumulator processor (PC, IR, memory address, acc strobes).
// Latency : 3 cycles per instruction, 4 for memory-operand ALU ops; strobes are one-cycle decodes of state/IR.
// Backpr. : none; memory is fixed one-cycle read latency, HALT parks the sequencer until rst.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   mem_addr      memory address (combinational from state/pc/ir)
//   mem_rdata     memory read data, valid the cycle after mem_addr
//   mem_we        store strobe (STA); accumulator supplies write data
//   acc_zero      accumulator == 0, sampled only in JZ execute
//   acc_ld/alu_op accumulator load enable and ALU select (00 pass, 01 add, 10 sub, 11 and)
//   acc_set_n     active-low set-all-ones to accumulator cells
//   acc_clr_n     active-low clear to accumulator cells (also low during rst)
//   pc, state     program counter and FSM state (0 FETCH .. 4 HALT)
//   halted        high while parked in HALT
module acc_seq_ctrl #(
   parameter int          DATA_W   = 8,
   parameter int          ADDR_W   = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   input  logic              acc_zero,
   output logic              acc_ld,
   output logic [1:0]        alu_op,
   output logic              acc_set_n,
   output logic              acc_clr_n,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        state,
   output logic              halted
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_CLR = 4'h5;
   localparam logic [3:0] OP_SET = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_STA = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;

   logic [3:0]          opcode;
   logic [ADDR_W-1:0]   operand;

   // Raw strobes before reset gating.
   logic                acc_ld_raw;
   logic [1:0]          alu_op_raw;
   logic                mem_we_raw;
   logic                set_raw;
   logic                clr_raw;

   assign opcode  = ir_q[DATA_W-1 -: 4];
   assign operand = ir_q[ADDR_W-1:0];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mem_addr   = pc_q;
      acc_ld_raw = 1'b0;
      alu_op_raw = 2'b00;
      mem_we_raw = 1'b0;
      set_raw    = 1'b0;
      clr_raw    = 1'b0;

      case (state_q)
         ST_FETCH: begin
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            // Instruction word addressed in FETCH arrives now.
            ir_d    = mem_rdata;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
                  // Present operand address now so data is valid in WB.
                  mem_addr = operand;
                  state_d  = ST_WB;
               end
               OP_CLR: clr_raw = 1'b1;
               OP_SET: set_raw = 1'b1;
               OP_JMP: pc_d = operand;
               OP_JZ: begin
                  if (acc_zero) begin
                     pc_d = operand;
                  end
               end
               OP_STA: begin
                  mem_addr   = operand;
                  mem_we_raw = 1'b1;
               end
               OP_HLT: state_d = ST_HALT;
               default: ; // OP_NOP and 0xA-0xE
            endcase
         end

         ST_WB: begin
            mem_addr   = operand;
            acc_ld_raw = 1'b1;
            case (opcode)
               OP_ADD:  alu_op_raw = 2'b01;
               OP_SUB:  alu_op_raw = 2'b10;
               OP_AND:  alu_op_raw = 2'b11;
               default: alu_op_raw = 2'b00; // LDA passes memory data
            endcase
            state_d = ST_FETCH;
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC_W;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Reset aborts any in-flight instruction: no load, store or set may escape
   // in a reset cycle, while clear is forced so the accumulator resets on the
   // same edge as the sequencer.
   assign acc_ld    = acc_ld_raw & ~rst;
   assign alu_op    = acc_ld ? alu_op_raw : 2'b00;
   assign mem_we    = mem_we_raw & ~rst;
   assign acc_set_n = ~(set_raw & ~rst);
   assign acc_clr_n = ~(clr_raw | rst);

   assign pc     = pc_q;
   assign state  = state_q;
   assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Purpose : self-checking bench for acc_seq_ctrl; bench acts as the memory by supplying mem_rdata per cycle.
// Latency : inputs applied after falling edge, outputs compared 1 time unit later, state advances on rising edge.
// Backpr. : none; every step is one clock, no waits on DUT events.
module tb_acc_seq_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_we;
   logic       acc_zero;
   logic       acc_ld;
   logic [1:0] alu_op;
   logic       acc_set_n;
   logic       acc_clr_n;
   logic [3:0] pc;
   logic [2:0] state;
   logic       halted;

   int n_chk;
   int n_fail;

   acc_seq_ctrl #(.DATA_W(8), .ADDR_W(4), .RESET_PC(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .acc_zero  (acc_zero),
      .acc_ld    (acc_ld),
      .alu_op    (alu_op),
      .acc_set_n (acc_set_n),
      .acc_clr_n (acc_clr_n),
      .pc        (pc),
      .state     (state),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // full=0 marks reset cycles where only the strobes are defined.
   typedef struct {
      bit         full;
      bit         r;
      logic [7:0] rd;
      bit         z;
      logic [2:0] st;
      logic [3:0] pc;
      logic [3:0] a;
      bit         ld;
      logic [1:0] op;
      bit         we;
      bit         sn;
      bit         cn;
      bit         h;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(bit f, bit r, logic [7:0] rd, bit z, logic [2:0] st,
                              logic [3:0] p, logic [3:0] a, bit ld, logic [1:0] op,
                              bit we, bit sn, bit cn, bit h);
      vec_t t;
      t.full = f; t.r = r; t.rd = rd; t.z = z; t.st = st; t.pc = p; t.a = a;
      t.ld = ld; t.op = op; t.we = we; t.sn = sn; t.cn = cn; t.h = h;
      return t;
   endfunction

   // Reset cycle: strobes quiet, clear asserted.
   function automatic vec_t R();
      return V(0, 1, 8'h00, 0, 3'd0, 4'h0, 4'h0, 0, 2'b00, 0, 1, 0, 0);
   endfunction

   // Ordinary cycle with all strobes inactive.
   function automatic vec_t P(logic [7:0] rd, bit z, logic [2:0] st, logic [3:0] p, logic [3:0] a);
      return V(1, 0, rd, z, st, p, a, 0, 2'b00, 0, 1, 1, 0);
   endfunction

   task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @vec %0d: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(vec_t t, int idx);
      rst       = t.r;
      mem_rdata = t.rd;
      acc_zero  = t.z;
      #1;
      chk("acc_ld",    idx, {7'd0, acc_ld},    {7'd0, t.ld});
      chk("alu_op",    idx, {6'd0, alu_op},    {6'd0, t.op});
      chk("mem_we",    idx, {7'd0, mem_we},    {7'd0, t.we});
      chk("acc_set_n", idx, {7'd0, acc_set_n}, {7'd0, t.sn});
      chk("acc_clr_n", idx, {7'd0, acc_clr_n}, {7'd0, t.cn});
      if (t.full) begin
         chk("state",    idx, {5'd0, state},    {5'd0, t.st});
         chk("pc",       idx, {4'd0, pc},       {4'd0, t.pc});
         chk("mem_addr", idx, {4'd0, mem_addr}, {4'd0, t.a});
         chk("halted",   idx, {7'd0, halted},   {7'd0, t.h});
      end
      @(negedge clk);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      mem_rdata = 8'h00;
      acc_zero  = 1'b0;

      // Reset for two cycles, then program {LDA 5, ADD 6, HLT}; mem[5]=3, mem[6]=4.
      tbl.push_back(R());
      tbl.push_back(R());
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h0, 4'h0));                          // c1 FETCH
      tbl.push_back(P(8'h15, 0, 3'd1, 4'h0, 4'h0));                          // c2 DECODE LDA 5
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h1, 4'h5));                          // c3 EXEC
      tbl.push_back(V(1, 0, 8'h03, 0, 3'd3, 4'h1, 4'h5, 1, 2'b00, 0, 1, 1, 0)); // c4 WB
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h1, 4'h1));                          // c5
      tbl.push_back(P(8'h26, 0, 3'd1, 4'h1, 4'h1));                          // c6 ADD 6
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h2, 4'h6));                          // c7
      tbl.push_back(V(1, 0, 8'h04, 0, 3'd3, 4'h2, 4'h6, 1, 2'b01, 0, 1, 1, 0)); // c8 WB
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h2, 4'h2));                          // c9
      tbl.push_back(P(8'hF0, 0, 3'd1, 4'h2, 4'h2));                          // c10 HLT
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h3, 4'h3));                          // c11 EXEC
      tbl.push_back(V(1, 0, 8'h00, 0, 3'd4, 4'h3, 4'h3, 0, 2'b00, 0, 1, 1, 1)); // HALT
      tbl.push_back(V(1, 0, 8'hFF, 1, 3'd4, 4'h3, 4'h3, 0, 2'b00, 0, 1, 1, 1)); // stays
      // Reset while halted, then JZ 9 taken.
      tbl.push_back(R());
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h0, 4'h0));
      tbl.push_back(P(8'h89, 0, 3'd1, 4'h0, 4'h0));
      tbl.push_back(P(8'h00, 1, 3'd2, 4'h1, 4'h1));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h9, 4'h9));
      // JZ 9 not taken.
      tbl.push_back(R());
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h0, 4'h0));
      tbl.push_back(P(8'h89, 0, 3'd1, 4'h0, 4'h0));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h1, 4'h1));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h1, 4'h1));
      // CLR then SET.
      tbl.push_back(P(8'h50, 0, 3'd1, 4'h1, 4'h1));
      tbl.push_back(V(1, 0, 8'h00, 0, 3'd2, 4'h2, 4'h2, 0, 2'b00, 0, 1, 0, 0));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h2, 4'h2));
      tbl.push_back(P(8'h60, 0, 3'd1, 4'h2, 4'h2));
      tbl.push_back(V(1, 0, 8'h00, 0, 3'd2, 4'h3, 4'h3, 0, 2'b00, 0, 0, 1, 0));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h3, 4'h3));
      // STA 7.
      tbl.push_back(P(8'h97, 0, 3'd1, 4'h3, 4'h3));
      tbl.push_back(V(1, 0, 8'h00, 0, 3'd2, 4'h4, 4'h7, 0, 2'b00, 1, 1, 1, 0));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h4, 4'h4));
      // SUB A and AND B select the remaining ALU ops.
      tbl.push_back(P(8'h3A, 0, 3'd1, 4'h4, 4'h4));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h5, 4'hA));
      tbl.push_back(V(1, 0, 8'h11, 0, 3'd3, 4'h5, 4'hA, 1, 2'b10, 0, 1, 1, 0));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h5, 4'h5));
      tbl.push_back(P(8'h4B, 0, 3'd1, 4'h5, 4'h5));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h6, 4'hB));
      tbl.push_back(V(1, 0, 8'h22, 0, 3'd3, 4'h6, 4'hB, 1, 2'b11, 0, 1, 1, 0));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h6, 4'h6));
      // JMP E, NOP at E, NOP at F wraps pc to 0, then opcode A behaves as NOP.
      tbl.push_back(P(8'h7E, 0, 3'd1, 4'h6, 4'h6));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h7, 4'h7));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'hE, 4'hE));
      tbl.push_back(P(8'h00, 0, 3'd1, 4'hE, 4'hE));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'hF, 4'hF));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'hF, 4'hF));
      tbl.push_back(P(8'h00, 0, 3'd1, 4'hF, 4'hF));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h0, 4'h0));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h0, 4'h0));
      tbl.push_back(P(8'hA3, 0, 3'd1, 4'h0, 4'h0));
      tbl.push_back(P(8'h00, 0, 3'd2, 4'h1, 4'h1));
      tbl.push_back(P(8'h00, 0, 3'd0, 4'h1, 4'h1));

      @(negedge clk);
      foreach (tbl[i]) run_vec(tbl[i], i);

      // Reset landing in the WB cycle of ADD 6 must suppress the load.
      rst = 1'b1; mem_rdata = 8'h00; acc_zero = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1; chk("wb_rst_fetch_state", 100, {5'd0, state}, 8'd0);
      @(negedge clk);
      mem_rdata = 8'h26;
      #1; chk("wb_rst_decode_state", 101, {5'd0, state}, 8'd1);
      @(negedge clk);
      mem_rdata = 8'h00;
      #1; chk("wb_rst_exec_addr", 102, {4'd0, mem_addr}, 8'h06);
      @(negedge clk);
      rst = 1'b1; mem_rdata = 8'h04;
      #1;
      chk("wb_rst_acc_ld",    103, {7'd0, acc_ld},    8'd0);
      chk("wb_rst_alu_op",    103, {6'd0, alu_op},    8'd0);
      chk("wb_rst_acc_clr_n", 103, {7'd0, acc_clr_n}, 8'd0);
      @(negedge clk);
      rst = 1'b0; mem_rdata = 8'h00;
      #1;
      chk("wb_rst_after_state",  104, {5'd0, state},  8'd0);
      chk("wb_rst_after_pc",     104, {4'd0, pc},     8'd0);
      chk("wb_rst_after_halted", 104, {7'd0, halted}, 8'd0);
      chk("wb_rst_after_acc_ld", 104, {7'd0, acc_ld}, 8'd0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
